// File: rtl/serial_shift_right_pkg.sv
// Shared types and default widths for the serial right shifter.
// The optional SHIFTR_NIBBLE_EN build adds a 4-bit step; types are unaffected.
package shift_pkg;

    localparam int SHR_XLEN    = 32;
    localparam int SHR_SHAMT_W = 5;

    // Largest step width taken per edge when SHIFTR_NIBBLE_EN is defined.
    localparam int SHR_NIBBLE  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shr_state_t;

endpackage : shift_pkg

// File: rtl/serial_shift_right_if.sv
// Request/response bundle between the control unit and the serial right shifter.
// Builds with or without SHIFTR_NIBBLE_EN expose the same signals.
interface serial_shift_right_if
    import shift_pkg::*;
#(
    parameter int XLEN    = SHR_XLEN,
    parameter int SHAMT_W = SHR_SHAMT_W
);

    // Handshake: start_i is sampled on every rising edge and is accepted only
    // while busy_o is low (state IDLE or DONE); a start seen while busy_o is
    // high is dropped, never queued. The operands need only be valid in the
    // accepting cycle. result_o is valid for consumption while done_o is high
    // and is then held until the next accepted start.
    logic               start_i;
    logic               arith_i;
    logic [XLEN-1:0]    data_i;
    logic [SHAMT_W-1:0] shamt_i;
    logic               busy_o;
    logic               done_o;
    logic [XLEN-1:0]    result_o;
    shr_state_t         state_o;

    modport master (
        output start_i,
        output arith_i,
        output data_i,
        output shamt_i,
        input  busy_o,
        input  done_o,
        input  result_o,
        input  state_o
    );

    modport slave (
        input  start_i,
        input  arith_i,
        input  data_i,
        input  shamt_i,
        output busy_o,
        output done_o,
        output result_o,
        output state_o
    );

endinterface : serial_shift_right_if

// File: rtl/serial_shift_right_step.sv
// One combinational shift step: right by 1 with fill, or by 4 when
// SHIFTR_NIBBLE_EN is defined and the nibble select is raised.
module shift_right_step
    import shift_pkg::*;
#(
    parameter int XLEN = SHR_XLEN
) (
    input  logic [XLEN-1:0] i_word,
    input  logic            i_fill,
`ifdef SHIFTR_NIBBLE_EN
    input  logic            i_nibble,
`endif
    output logic [XLEN-1:0] o_word
);

    logic [XLEN-1:0] w_by_one;

    assign w_by_one = {i_fill, i_word[XLEN-1:1]};

`ifdef SHIFTR_NIBBLE_EN
    logic [XLEN-1:0] w_by_nibble;

    assign w_by_nibble = {{SHR_NIBBLE{i_fill}}, i_word[XLEN-1:SHR_NIBBLE]};

    always_comb begin
        o_word = w_by_one;
        if (i_nibble) begin
            o_word = w_by_nibble;
        end
    end
`else
    always_comb begin
        o_word = w_by_one;
    end
`endif

endmodule : shift_right_step

// File: rtl/serial_shift_right.sv
// Multi-cycle SRL/SRA unit: FSM, shift counter, work register and fill latch.
// Define SHIFTR_NIBBLE_EN to retire 4 bits per edge while the counter allows.
module serial_shift_right
    import shift_pkg::*;
#(
    parameter int XLEN    = SHR_XLEN,
    parameter int SHAMT_W = SHR_SHAMT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_shift_right_if.slave  bus
);

    shr_state_t         r_state;
    shr_state_t         w_state_nxt;
    logic [XLEN-1:0]    r_work;
    logic [XLEN-1:0]    w_work_nxt;
    logic               r_fill;
    logic               w_fill_nxt;
    logic [SHAMT_W-1:0] r_cnt;
    logic [SHAMT_W-1:0] w_cnt_nxt;

    logic [XLEN-1:0]    w_step_word;
    logic [SHAMT_W-1:0] w_step_amt;

`ifdef SHIFTR_NIBBLE_EN
    logic               w_nibble;

    assign w_nibble   = (r_cnt >= SHAMT_W'(SHR_NIBBLE));
    assign w_step_amt = w_nibble ? SHAMT_W'(SHR_NIBBLE) : SHAMT_W'(1);

    shift_right_step #(
        .XLEN     (XLEN)
    ) u_step (
        .i_word   (r_work),
        .i_fill   (r_fill),
        .i_nibble (w_nibble),
        .o_word   (w_step_word)
    );
`else
    assign w_step_amt = SHAMT_W'(1);

    shift_right_step #(
        .XLEN     (XLEN)
    ) u_step (
        .i_word   (r_work),
        .i_fill   (r_fill),
        .o_word   (w_step_word)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_work  <= '0;
            r_fill  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_fill  <= w_fill_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_fill_nxt  = r_fill;
        w_cnt_nxt   = r_cnt;

        unique case (r_state)
            IDLE, DONE: begin
                w_state_nxt = IDLE;
                if (bus.start_i) begin
                    w_state_nxt = SHIFT;
                    w_work_nxt  = bus.data_i;
                    w_fill_nxt  = bus.arith_i & bus.data_i[XLEN-1];
                    w_cnt_nxt   = bus.shamt_i;
                end
            end

            SHIFT: begin
                // A zero amount still spends one cycle here so latency is never 0.
                if (r_cnt == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_work_nxt = w_step_word;
                    w_cnt_nxt  = r_cnt - w_step_amt;
                    if (r_cnt == w_step_amt) begin
                        w_state_nxt = DONE;
                    end
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy_o   = (r_state == SHIFT);
    assign bus.done_o   = (r_state == DONE);
    assign bus.result_o = r_work;
    assign bus.state_o  = r_state;

endmodule : serial_shift_right

// File: tb/tb_serial_shift_right.sv
// Directed and randomized checks of serial_shift_right against a shift-operator model.
// Honors SHIFTR_NIBBLE_EN for the expected latency.
module tb_serial_shift_right;
  import shift_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [31:0] exp_q[$];
  logic [31:0] last_res;

  serial_shift_right_if bus ();

  serial_shift_right dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input bit a);
    logic [31:0] r;
    if (a) r = $signed(d) >>> s;
    else   r = d >> s;
    return r;
  endfunction

  function automatic int ref_lat(input int s);
    int r;
`ifdef SHIFTR_NIBBLE_EN
    r = s / 4 + s % 4;
`else
    r = s;
`endif
    return (r < 1) ? 1 : r;
  endfunction

  task automatic check(input string tag, input string what, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s/%s: observed 0x%08h expected 0x%08h", tag, what, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: launch at the current (post-edge) time, finish in the DONE cycle
  task automatic run_op(input string tag, input bit arith, input logic [31:0] data,
                        input int s, input logic [31:0] exp_res, input int poke);
    int k;
    bit busy_ok;
    int lat;
    lat = ref_lat(s);
    exp_q.push_back(exp_res);
    bus.start_i = 1'b1;
    bus.arith_i = arith;
    bus.data_i  = data;
    bus.shamt_i = 5'(s);
    tick();
    bus.start_i = 1'b0;
    bus.data_i  = $urandom;
    bus.arith_i = 1'($urandom_range(0, 1));
    bus.shamt_i = 5'($urandom_range(0, 31));
    check(tag, "done_low_after_start", {31'b0, bus.done_o}, 32'd0);
    k = 0;
    busy_ok = 1'b1;
    while (bus.done_o !== 1'b1 && k < 40) begin
      if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
      if (k == poke) begin
        bus.start_i = 1'b1;
        bus.data_i  = 32'h0;
      end else begin
        bus.start_i = 1'b0;
      end
      tick();
      k++;
    end
    bus.start_i = 1'b0;
    check(tag, "latency", 32'(k), 32'(lat));
    check(tag, "busy_while_shifting", {31'b0, busy_ok}, 32'd1);
    check(tag, "busy_at_done", {31'b0, bus.busy_o}, 32'd0);
    check(tag, "state_at_done", 32'(bus.state_o), 32'(DONE));
    check(tag, "result", bus.result_o, exp_q.pop_front());
    last_res = exp_res;
  endtask

  task automatic check_idle(input string tag);
    tick();
    check(tag, "done_dropped", {31'b0, bus.done_o}, 32'd0);
    check(tag, "idle_busy", {31'b0, bus.busy_o}, 32'd0);
    check(tag, "result_held", bus.result_o, last_res);
  endtask

  // stimulus
  initial begin
    int s;
    int gap;
    int pulses;
    bit a;
    logic [31:0] d;
    n_checks    = 0;
    n_errors    = 0;
    last_res    = 32'h0;
    rst_n       = 1'b0;
    bus.start_i = 1'b0;
    bus.arith_i = 1'b0;
    bus.data_i  = 32'h0;
    bus.shamt_i = 5'd0;
    repeat (2) tick();
    check("reset", "busy", {31'b0, bus.busy_o}, 32'd0);
    check("reset", "done", {31'b0, bus.done_o}, 32'd0);
    check("reset", "result", bus.result_o, 32'h0);
    check("reset", "state", 32'(bus.state_o), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    run_op("srl31", 1'b0, 32'h8000_0000, 31, 32'h0000_0001, -1);
    check_idle("srl31");
    run_op("sra4_neg", 1'b1, 32'h8000_0000, 4, 32'hF800_0000, -1);
    check_idle("sra4_neg");
    run_op("sra4_pos", 1'b1, 32'h7000_0000, 4, 32'h0700_0000, -1);
    check_idle("sra4_pos");
    run_op("s0_srl", 1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, -1);
    check_idle("s0_srl");
    run_op("s0_sra", 1'b1, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, -1);
    check_idle("s0_sra");

    // a start while busy must be dropped
    run_op("ignored", 1'b0, 32'hFFFF_FFFF, 8, 32'h00FF_FFFF, (ref_lat(8) > 3) ? 3 : ref_lat(8) - 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.done_o === 1'b1 || bus.busy_o === 1'b1) pulses++;
    end
    check("ignored", "extra_activity", 32'(pulses), 32'd0);
    check("ignored", "result_kept", bus.result_o, 32'h00FF_FFFF);

    // asynchronous reset mid-operation
    bus.start_i = 1'b1;
    bus.arith_i = 1'b0;
    bus.data_i  = $urandom | 32'h8000_0000;
    bus.shamt_i = 5'd20;
    tick();
    bus.start_i = 1'b0;
    repeat (4) tick();
    check("abort", "busy_before", {31'b0, bus.busy_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort", "busy", {31'b0, bus.busy_o}, 32'd0);
    check("abort", "done", {31'b0, bus.done_o}, 32'd0);
    check("abort", "result", bus.result_o, 32'h0);
    #10 rst_n = 1'b1;
    tick();
    run_op("after_reset", 1'b1, 32'hFFFF_0000, 16, 32'hFFFF_FFFF, -1);
    check_idle("after_reset");

    // back-to-back start in the DONE cycle
    tick();
    run_op("b2b_first", 1'b0, 32'h0000_00F0, 4, 32'h0000_000F, -1);
    run_op("b2b_second", 1'b1, 32'h8000_0000, 1, 32'hC000_0000, -1);
    check_idle("b2b_second");

    // randomized operations against the model
    for (int i = 0; i < 24; i++) begin
      s = (i == 0) ? 0 : (i == 1) ? 31 : $urandom_range(0, 31);
      a = 1'($urandom_range(0, 1));
      d = $urandom;
      run_op($sformatf("rand%0d", i), a, d, s, ref_shift(d, s, a), -1);
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        check_idle($sformatf("rand%0d", i));
        repeat (gap - 1) tick();
      end
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_serial_shift_right

// File: doc/serial_shift_right.md
# serial_shift_right

Multi-cycle right shifter for the RV32 ALU path. It executes SRL/SRLI (logical) and SRA/SRAI (arithmetic) by iterating a shift register, so there is no wide barrel shifter. It is the right-direction counterpart of the datapath's one-bit left shifter. The control unit launches an operation with a start pulse, holds the pipeline while `busy_o` is high, and captures `result_o` on the `done_o` pulse.

## Interface
- `XLEN`, 32: data width.
- `SHAMT_W`, 5: shift-amount width, equal to log2(XLEN).
- `clk` input 1: single clock. All state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start_i` input 1: request pulse. Sampled on the rising edge.
- `arith_i` input 1: 1 = arithmetic (sign fill), 0 = logical (zero fill).
- `data_i` input XLEN: operand (rs1).
- `shamt_i` input SHAMT_W: shift amount (rs2[4:0] or imm[4:0]).
- `busy_o` output 1: operation in progress; new starts are ignored.
- `done_o` output 1: one-cycle pulse; `result_o` is valid.
- `result_o` output XLEN: shifted result. Held until the next accepted start.

## Operation
- FSM states and transitions:
  - IDLE: accepts start.
  - SHIFT: shift register and counter active.
  - DONE: `done_o`=1, accepts start.
- Start acceptance:
  - Accepted only in IDLE or DONE.
  - On acceptance: work register ← `data_i`, fill bit ← `arith_i` & `data_i`[XLEN-1] (latched), counter ← `shamt_i`, state → SHIFT.
  - `start_i` while in SHIFT is ignored. No queuing, no error.
- In SHIFT each edge does one of:
  - counter > 1: shift right 1, insert fill bit at MSB, counter −1.
  - counter == 1: same shift, counter → 0, state → DONE.
  - counter == 0 (`shamt_i` was 0): no shift, state → DONE.
- DONE lasts one cycle. It returns to IDLE unless a new start is accepted, in which case it goes to SHIFT.
- Only `shamt_i`[SHAMT_W-1:0] is used. Shift amounts are 0..31 and never wrap.
- `result_o` is the work register. During SHIFT it shows intermediate values and must only be consumed on `done_o`.
- Output decoding: `busy_o` = (state == SHIFT); `done_o` = (state == DONE).

## Timing
- Reset (asynchronous assert, synchronous-safe release):
  - state = IDLE, `busy_o` = 0, `done_o` = 0, `result_o` = 0, counter = 0.
  - Reset mid-operation aborts immediately. No partial result is retained.
- Latency: with the start accepted at edge E0 and amount s, `done_o` is high for the single cycle after edge E(max(s,1)).
  - s = 0 → 1 cycle; s = 31 → 31 cycles.
- `busy_o` rises the cycle after acceptance and falls when `done_o` rises. Both are registered-state decodes with no combinational path from inputs.
- Back-to-back: a start in the DONE cycle is accepted. `done_o` then drops and `busy_o` rises on the next cycle.
- `arith_i`, `data_i` and `shamt_i` need only be valid in the acceptance cycle.

## Configuration
- `SHIFTR_NIBBLE_EN` defined:
  - While counter ≥ 4, SHIFT shifts 4 bits per edge (4 fill bits), counter −4. Otherwise it shifts 1 bit.
  - DONE is entered on the edge that brings the counter to 0.
  - Latency = max(⌊s/4⌋ + (s mod 4), 1).
- Undefined: 1 bit per edge only, with the latency stated above.
- The interface and final results are identical in both builds.

## Structure
- Package `shift_pkg`:
  - `XLEN`/`SHAMT_W` defaults.
  - Enum `shr_state_t` {IDLE, SHIFT, DONE}.
- Sub-module `shift_right_step`:
  - Combinational: inputs word, fill bit, step-select; output word shifted right by 1, or by 4 when nibble mode is enabled.
- Top level holds the FSM, counter, work register and fill latch.

## Test plan
- SRL, `data_i`=0x8000_0000, s=31 → `result_o`=0x0000_0001; `done_o` 31 cycles after start (nibble build: 10).
- SRA, `data_i`=0x8000_0000, s=4 → 0xF800_0000; SRA 0x7000_0000, s=4 → 0x0700_0000; latency 4 (nibble: 1).
- s=0, `data_i`=0xDEAD_BEEF, either mode → 0xDEAD_BEEF; `done_o` 1 cycle after start; `busy_o` high exactly 1 cycle.
- Start SRL 0xFFFF_FFFF, s=8, then pulse `start_i` with `data_i`=0 three cycles later → ignored; result 0x00FF_FFFF; exactly one `done_o` pulse.
- SRL s=20 started; `rst_n` low during cycle 5 → `busy_o`/`done_o`/`result_o` go to 0 without waiting for an edge. After release, SRA 0xFFFF_0000, s=16 → 0xFFFF_FFFF.
- Start in the DONE cycle of SRL 0x0000_00F0, s=4 (result 0x0000_000F) with SRA 0x8000_0000, s=1 → accepted; second result 0xC000_0000; two distinct `done_o` pulses.
